// File: rtl/pattern_gen.sv
// pattern_gen: MSB-first serial pattern generator with repeat count; even parity bit per repetition when PATTERN_GEN_PARITY_EN is defined
module pattern_gen #(
  parameter int WIDTH = 16,
  parameter int LW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] pat,
  input  logic [LW-1:0]    len,
  input  logic [3:0]       reps,
  output logic             a,
  output logic             a_valid,
  output logic             busy,
  output logic             done
);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [WIDTH-1:0] pat_q, mask;
  logic [LW-1:0] len_c, top, top_q, cnt;
  logic [3:0] rem;
  logic cur;
  assign len_c = len > LW'(WIDTH) ? LW'(WIDTH) : len;
  assign mask = len_c == '0 ? '0 : {WIDTH{1'b1}} >> (LW'(WIDTH) - len_c);
`ifdef PATTERN_GEN_PARITY_EN
  assign top = len_c;
  assign cur = cnt == '0 ? ^pat_q : |({pat_q, 1'b0} & ((WIDTH + 1)'(1) << cnt));
`else
  assign top = len_c - 1'b1;
  assign cur = |(pat_q & (WIDTH'(1) << cnt));
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else if (state == IDLE) begin
      if (start_valid) begin
        pat_q <= pat & mask;
        top_q <= top;
        cnt   <= top;
        rem   <= reps == '0 ? '0 : reps - 1'b1;
        state <= len_c == '0 ? DONE : SHIFT;
      end
    end else if (state == SHIFT) begin
      cnt   <= cnt == '0 ? top_q : cnt - 1'b1;
      rem   <= cnt == '0 ? rem - 1'b1 : rem;
      state <= cnt == '0 && rem == '0 ? DONE : SHIFT;
    end else begin
      state <= IDLE;
    end
  end
  assign start_ready = state == IDLE;
  assign busy        = state != IDLE;
  assign done        = state == DONE;
  assign a_valid     = state == SHIFT;
  assign a           = a_valid & cur;
endmodule
